// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore packet controller: packet layout, op codes,
// controller state encoding and the packet-width helper.
package bsg_manycore_pkg;

  localparam int x_cord_width_gp = 5;
  localparam int y_cord_width_gp = 5;
  localparam int data_width_gp   = 32;
  localparam int addr_width_gp   = 14;

  // Known op codes; anything else is counted as unknown.
  typedef enum logic [5:0] {
    e_op_remote_store = 6'd1,
    e_op_config       = 6'd2
  } bsg_manycore_op_e;

  // Controller states: nothing held, or one store held in the output register.
  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_pend = 1'b1
  } bsg_manycore_ctrl_state_e;

  // Packet layout at the default widths, MSB to LSB.
  typedef struct packed {
    logic [5:0]                 op;
    logic [addr_width_gp-1:0]   addr;
    logic [data_width_gp-1:0]   data;
    logic [y_cord_width_gp-1:0] from_y;
    logic [x_cord_width_gp-1:0] from_x;
    logic [y_cord_width_gp-1:0] y;
    logic [x_cord_width_gp-1:0] x;
  } bsg_manycore_packet_s;

  // Total packet width for a given set of field widths.
  function automatic int packet_width(input int x_w, input int y_w,
                                      input int data_w, input int addr_w);
    return 6 + 2 * (x_w + y_w) + data_w + addr_w;
  endfunction

endpackage

// File: rtl/bsg_counter_sat.sv
// Increment-only counter that sticks at its all-ones value instead of wrapping.
module bsg_counter_sat #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  localparam logic [width_p-1:0] one_lp = {{(width_p-1){1'b0}}, 1'b1};

  logic [width_p-1:0] count_r;

  // Count up on request, holding once every bit is set.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r <= {width_p{1'b0}};
    end else if (up_i && !(&count_r)) begin
      count_r <= count_r + one_lp;
    end else begin
      count_r <= count_r;
    end
  end

  assign count_o = count_r;

endmodule

// File: rtl/bsg_manycore_pkt_ctrl_chk.sv
// Protocol checks for the packet controller's memory-side handshake.
module bsg_manycore_pkt_ctrl_chk (
  input logic clk_i,
  input logic reset_i,
  input logic mem_v_i,
  input logic mem_yumi_i
);

  // Memory may only consume a request that is actually being offered.
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_yumi_i |-> mem_v_i);

endmodule

// File: rtl/bsg_manycore_pkt_ctrl.sv
// Sequencing controller for the tile's incoming manycore packet stream:
// forwards remote stores to local memory, applies config writes to the freeze
// register, counts unknown ops and returns one credit per retired packet.
module bsg_manycore_pkt_ctrl
  import bsg_manycore_pkg::*;
#(
  parameter  int x_cord_width_p  = 5,
  parameter  int y_cord_width_p  = 5,
  parameter  int data_width_p    = 32,
  parameter  int addr_width_p    = 14,
  localparam int packet_width_lp = packet_width(x_cord_width_p, y_cord_width_p,
                                                data_width_p, addr_width_p)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  input  logic [packet_width_lp-1:0] data_i,
  output logic                      ready_o,
  output logic                      mem_v_o,
  output logic [addr_width_p-1:0]   mem_addr_o,
  output logic [data_width_p-1:0]   mem_data_o,
  output logic [x_cord_width_p-1:0] mem_from_x_o,
  output logic [y_cord_width_p-1:0] mem_from_y_o,
  input  logic                      mem_yumi_i,
  output logic                      freeze_o,
  output logic [1:0]                credit_o,
  output logic [15:0]               unknown_cnt_o
);

  // Field positions inside the packet, LSB first.
  localparam int x_lsb_lp      = 0;
  localparam int y_lsb_lp      = x_lsb_lp + x_cord_width_p;
  localparam int from_x_lsb_lp = y_lsb_lp + y_cord_width_p;
  localparam int from_y_lsb_lp = from_x_lsb_lp + x_cord_width_p;
  localparam int data_lsb_lp   = from_y_lsb_lp + y_cord_width_p;
  localparam int addr_lsb_lp   = data_lsb_lp + data_width_p;
  localparam int op_lsb_lp     = addr_lsb_lp + addr_width_p;

  logic [5:0]                op_s;
  logic [addr_width_p-1:0]   addr_s;
  logic [data_width_p-1:0]   data_s;
  logic [x_cord_width_p-1:0] from_x_s;
  logic [y_cord_width_p-1:0] from_y_s;
  logic                      unused_dest_s;

  assign op_s          = data_i[op_lsb_lp +: 6];
  assign addr_s        = data_i[addr_lsb_lp +: addr_width_p];
  assign data_s        = data_i[data_lsb_lp +: data_width_p];
  assign from_x_s      = data_i[from_x_lsb_lp +: x_cord_width_p];
  assign from_y_s      = data_i[from_y_lsb_lp +: y_cord_width_p];
  // Destination coordinates were already used for routing; nothing to do here.
  assign unused_dest_s = ^data_i[from_x_lsb_lp-1:0];

  bsg_manycore_ctrl_state_e  state_r;
  logic                      mem_v_r;
  logic [addr_width_p-1:0]   mem_addr_r;
  logic [data_width_p-1:0]   mem_data_r;
  logic [x_cord_width_p-1:0] mem_from_x_r;
  logic [y_cord_width_p-1:0] mem_from_y_r;
  logic                      freeze_r;
  logic [1:0]                credit_r;

  logic is_store_s;
  logic is_cfg_s;
  logic is_unknown_s;
  logic yumi_s;
  logic ready_s;
  logic accept_s;
  logic store_acc_s;
  logic cfg_acc_s;
  logic unknown_acc_s;
  logic nonstore_acc_s;
  logic [1:0] retire_s;

  // Classify the op of the packet on the input.
  always_comb begin
    is_store_s   = 1'b0;
    is_cfg_s     = 1'b0;
    is_unknown_s = 1'b0;
    case (op_s)
      e_op_remote_store: is_store_s   = 1'b1;
      e_op_config:       is_cfg_s     = 1'b1;
      default:           is_unknown_s = 1'b1;
    endcase
  end

  // A yumi with nothing pending is illegal and is simply ignored. The path
  // from mem_yumi_i to ready_o is deliberate: it lets a zero-wait memory
  // sustain one store per cycle.
  assign yumi_s         = mem_yumi_i & (state_r == e_pend);
  assign ready_s        = (state_r == e_idle) | yumi_s;
  assign accept_s       = v_i & ready_s;
  assign store_acc_s    = accept_s & is_store_s;
  assign cfg_acc_s      = accept_s & is_cfg_s;
  assign unknown_acc_s  = accept_s & is_unknown_s;
  assign nonstore_acc_s = accept_s & ~is_store_s;
  assign retire_s       = {1'b0, nonstore_acc_s} + {1'b0, yumi_s};

  // Store sequencing, freeze register and credit return.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r      <= e_idle;
      mem_v_r      <= 1'b0;
      mem_addr_r   <= {addr_width_p{1'b0}};
      mem_data_r   <= {data_width_p{1'b0}};
      mem_from_x_r <= {x_cord_width_p{1'b0}};
      mem_from_y_r <= {y_cord_width_p{1'b0}};
      freeze_r     <= 1'b1;
      credit_r     <= 2'd0;
    end else begin
      credit_r <= retire_s;

      if (cfg_acc_s && (addr_s == {addr_width_p{1'b0}})) begin
        freeze_r <= data_s[0];
      end

      case (state_r)
        e_idle: begin
          if (store_acc_s) begin
            state_r      <= e_pend;
            mem_v_r      <= 1'b1;
            mem_addr_r   <= addr_s;
            mem_data_r   <= data_s;
            mem_from_x_r <= from_x_s;
            mem_from_y_r <= from_y_s;
          end else begin
            mem_v_r <= 1'b0;
          end
        end
        e_pend: begin
          if (yumi_s && store_acc_s) begin
            // Hand-off without a bubble: the next store replaces the consumed one.
            mem_v_r      <= 1'b1;
            mem_addr_r   <= addr_s;
            mem_data_r   <= data_s;
            mem_from_x_r <= from_x_s;
            mem_from_y_r <= from_y_s;
          end else if (yumi_s) begin
            state_r <= e_idle;
            mem_v_r <= 1'b0;
          end else begin
            mem_v_r <= 1'b1;
          end
        end
        default: begin
          state_r <= e_idle;
          mem_v_r <= 1'b0;
        end
      endcase
    end
  end

  bsg_counter_sat #(
    .width_p(16)
  ) unknown_counter (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .up_i   (unknown_acc_s),
    .count_o(unknown_cnt_o)
  );

  bsg_manycore_pkt_ctrl_chk checker_inst (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .mem_v_i   (mem_v_r),
    .mem_yumi_i(mem_yumi_i)
  );

  assign ready_o      = ready_s;
  assign mem_v_o      = mem_v_r;
  assign mem_addr_o   = mem_addr_r;
  assign mem_data_o   = mem_data_r;
  assign mem_from_x_o = mem_from_x_r;
  assign mem_from_y_o = mem_from_y_r;
  assign freeze_o     = freeze_r;
  assign credit_o     = credit_r;

endmodule

// File: tb/tb_bsg_manycore_pkt_ctrl.sv
// Bench for the manycore packet controller: a queue-based reference model is
// checked against the DUT every cycle, plus literal checks at key points.
module tb_bsg_manycore_pkt_ctrl;
  import bsg_manycore_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        v_i;
  logic [71:0] data_i;
  logic        ready_o;
  logic        mem_v_o;
  logic [13:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic [4:0]  mem_from_x_o;
  logic [4:0]  mem_from_y_o;
  logic        mem_yumi_i;
  logic        freeze_o;
  logic [1:0]  credit_o;
  logic [15:0] unknown_cnt_o;

  bsg_manycore_pkt_ctrl dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .v_i          (v_i),
    .data_i       (data_i),
    .ready_o      (ready_o),
    .mem_v_o      (mem_v_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_from_x_o (mem_from_x_o),
    .mem_from_y_o (mem_from_y_o),
    .mem_yumi_i   (mem_yumi_i),
    .freeze_o     (freeze_o),
    .credit_o     (credit_o),
    .unknown_cnt_o(unknown_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Reference model: stores still owed to memory, in order.
  typedef struct {
    logic [13:0] a;
    logic [31:0] d;
    logic [4:0]  fx;
    logic [4:0]  fy;
  } store_t;
  store_t q[$];
  int     exp_freeze = 1;
  int     exp_credit = 0;
  int     exp_cnt    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] pkt(input logic [5:0] op, input logic [13:0] addr,
                                       input logic [31:0] data, input logic [4:0] fx,
                                       input logic [4:0] fy);
    bsg_manycore_packet_s p;
    p.op = op; p.addr = addr; p.data = data;
    p.from_x = fx; p.from_y = fy; p.y = 5'd3; p.x = 5'd4;
    return p;
  endfunction

  task automatic model_step();
    bsg_manycore_packet_s p;
    store_t s;
    int retire;
    bit yumi, acc;
    if (reset_i) begin
      q.delete();
      exp_freeze = 1; exp_credit = 0; exp_cnt = 0;
    end else begin
      retire = 0;
      yumi = mem_yumi_i && (q.size() != 0);
      acc  = v_i && ((q.size() == 0) || yumi);
      if (yumi) begin
        void'(q.pop_front());
        retire++;
      end
      if (acc) begin
        p = data_i;
        if (p.op == 6'd1) begin
          s.a = p.addr; s.d = p.data; s.fx = p.from_x; s.fy = p.from_y;
          q.push_back(s);
        end else begin
          retire++;
          if (p.op == 6'd2) begin
            if (p.addr == 14'd0) exp_freeze = int'(p.data[0]);
          end else if (exp_cnt < 65535) begin
            exp_cnt++;
          end
        end
      end
      exp_credit = retire;
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  // Compare every output against the model once per cycle.
  always @(negedge clk_i) begin
    if (chk_en) begin
      check("ready", 64'(ready_o), 64'((q.size() == 0) || (mem_yumi_i && q.size() != 0)));
      check("mem_v", 64'(mem_v_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
        check("mem_addr", 64'(mem_addr_o), 64'(q[0].a));
        check("mem_data", 64'(mem_data_o), 64'(q[0].d));
        check("mem_from_x", 64'(mem_from_x_o), 64'(q[0].fx));
        check("mem_from_y", 64'(mem_from_y_o), 64'(q[0].fy));
      end
      check("freeze", 64'(freeze_o), 64'(exp_freeze));
      check("credit", 64'(credit_o), 64'(exp_credit));
      check("unknown_cnt", 64'(unknown_cnt_o), 64'(exp_cnt));
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  initial begin
    reset_i = 1'b1; v_i = 1'b0; data_i = 72'd0; mem_yumi_i = 1'b0;
    step(); step();
    reset_i = 1'b0;
    chk_en = 1'b1;

    // Reset state.
    at_neg();
    check("lit_rst_freeze", 64'(freeze_o), 64'd1);
    check("lit_rst_mem_v", 64'(mem_v_o), 64'd0);
    check("lit_rst_credit", 64'(credit_o), 64'd0);
    check("lit_rst_cnt", 64'(unknown_cnt_o), 64'd0);
    check("lit_rst_ready", 64'(ready_o), 64'd1);

    // Config unfreeze, then a config to a nonzero address is dropped.
    step();
    v_i = 1'b1; data_i = pkt(6'd2, 14'd0, 32'd0, 5'd1, 5'd1);
    step();
    v_i = 1'b0;
    at_neg();
    check("lit_cfg_freeze", 64'(freeze_o), 64'd0);
    check("lit_cfg_credit", 64'(credit_o), 64'd1);
    check("lit_mdl_freeze", 64'(exp_freeze), 64'd0);
    v_i = 1'b1; data_i = pkt(6'd2, 14'd3, 32'd1, 5'd1, 5'd1);
    step();
    v_i = 1'b0;
    at_neg();
    check("lit_cfg2_freeze", 64'(freeze_o), 64'd0);
    check("lit_cfg2_credit", 64'(credit_o), 64'd1);

    // Single store with memory stalling three cycles.
    v_i = 1'b1; data_i = pkt(6'd1, 14'h10, 32'hDEADBEEF, 5'd2, 5'd6);
    step();
    v_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      at_neg();
      check("lit_st_mem_v", 64'(mem_v_o), 64'd1);
      check("lit_st_addr", 64'(mem_addr_o), 64'h10);
      check("lit_st_ready", 64'(ready_o), 64'd0);
      step();
    end
    mem_yumi_i = 1'b1;
    at_neg();
    check("lit_st_ready_yumi", 64'(ready_o), 64'd1);
    check("lit_st_data", 64'(mem_data_o), 64'hDEADBEEF);
    step();
    mem_yumi_i = 1'b0;
    at_neg();
    check("lit_st_credit", 64'(credit_o), 64'd1);
    check("lit_st_mem_v_off", 64'(mem_v_o), 64'd0);

    // Back-to-back stores under a zero-wait memory.
    v_i = 1'b1; data_i = pkt(6'd1, 14'h20, 32'h1000, 5'd0, 5'd0);
    step();
    for (int i = 1; i < 4; i++) begin
      data_i = pkt(6'd1, 14'h20 + 14'(i), 32'h1000 + 32'(i), 5'(i), 5'(i));
      mem_yumi_i = 1'b1;
      step();
      at_neg();
      check("lit_b2b_mem_v", 64'(mem_v_o), 64'd1);
      check("lit_b2b_addr", 64'(mem_addr_o), 64'h20 + 64'(i));
      check("lit_b2b_credit", 64'(credit_o), 64'd1);
    end
    v_i = 1'b0;
    step();
    mem_yumi_i = 1'b0;
    at_neg();
    check("lit_b2b_last_credit", 64'(credit_o), 64'd1);
    check("lit_b2b_drained", 64'(mem_v_o), 64'd0);

    // Double retire: yumi on a pending store while a config is accepted.
    v_i = 1'b1; data_i = pkt(6'd1, 14'h30, 32'h55AA, 5'd7, 5'd8);
    step();
    data_i = pkt(6'd2, 14'd0, 32'd1, 5'd0, 5'd0);
    mem_yumi_i = 1'b1;
    step();
    v_i = 1'b0; mem_yumi_i = 1'b0;
    at_neg();
    check("lit_dbl_credit", 64'(credit_o), 64'd2);
    check("lit_dbl_freeze", 64'(freeze_o), 64'd1);
    check("lit_mdl_dbl_credit", 64'(exp_credit), 64'd2);

    // Unknown ops until the counter saturates.
    v_i = 1'b1; data_i = pkt(6'd7, 14'd0, 32'd0, 5'd0, 5'd0);
    step();
    at_neg();
    check("lit_unk_one", 64'(unknown_cnt_o), 64'd1);
    check("lit_unk_credit", 64'(credit_o), 64'd1);
    repeat (65539) step();
    v_i = 1'b0;
    at_neg();
    check("lit_unk_sat", 64'(unknown_cnt_o), 64'hFFFF);
    check("lit_mdl_unk_sat", 64'(exp_cnt), 64'd65535);

    // Refreeze off, then reset while a store is pending.
    v_i = 1'b1; data_i = pkt(6'd2, 14'd0, 32'd0, 5'd0, 5'd0);
    step();
    data_i = pkt(6'd1, 14'h3F, 32'hCAFE, 5'd1, 5'd2);
    step();
    v_i = 1'b0;
    at_neg();
    check("lit_prerst_mem_v", 64'(mem_v_o), 64'd1);
    check("lit_prerst_freeze", 64'(freeze_o), 64'd0);
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    at_neg();
    check("lit_mrst_mem_v", 64'(mem_v_o), 64'd0);
    check("lit_mrst_credit", 64'(credit_o), 64'd0);
    check("lit_mrst_freeze", 64'(freeze_o), 64'd1);
    check("lit_mrst_cnt", 64'(unknown_cnt_o), 64'd0);
    step();
    at_neg();
    check("lit_mrst_credit2", 64'(credit_o), 64'd0);

    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
